// File: rtl/tag_cache_pkg.sv
// Shared types and helpers for the tag cache controller.
// The entry record fixes the stored tag/payload widths to the package defaults.
package tag_cache_pkg;

    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_INDEX_W = 5;
    localparam int DEFAULT_DEPTH   = 20;

    typedef struct packed {
        logic                       valid;
        logic [DEFAULT_INDEX_W-1:0] tag;
        logic [DEFAULT_DATA_W-1:0]  data;
    } entry_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lowest_free_enc.sv
// Priority encoder: index of the lowest set bit of free_vec plus an any-set flag.
module lowest_free_enc #(
    parameter int N     = 20,
    parameter int IDX_W = 5
) (
    input  logic [N-1:0]     free_vec,
    output logic [IDX_W-1:0] idx,
    output logic             any_free
);

    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        // Scanning downward lets the lowest free slot overwrite higher ones.
        for (int i = N - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                idx      = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tag_cache_ctrl.sv
// Two-writer tag-addressed store with consume-on-read lookup.
// Define TAG_CACHE_RR_EN for round-robin write arbitration (fixed priority otherwise).
module tag_cache_ctrl
    import tag_cache_pkg::*;
#(
    parameter int Data_Width  = DEFAULT_DATA_W,
    parameter int Index_Width = DEFAULT_INDEX_W,
    parameter int Depth       = DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_req_0,
    input  logic [Index_Width-1:0]        wr_index_0,
    input  logic [Data_Width-1:0]         wr_data_0,
    input  logic                          wr_req_1,
    input  logic [Index_Width-1:0]        wr_index_1,
    input  logic [Data_Width-1:0]         wr_data_1,
    output logic                          wr_gnt_0,
    output logic                          wr_gnt_1,
    input  logic                          rd_req,
    input  logic [Index_Width-1:0]        rd_index,
    output logic                          rd_valid,
    output logic                          rd_hit,
    output logic [Data_Width-1:0]         rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(Depth)-1:0] count
);

    localparam int CNT_W      = count_width(Depth);
    localparam int SLOT_W     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int ENT_TAG_W  = DEFAULT_INDEX_W;
    localparam int ENT_DATA_W = DEFAULT_DATA_W;

    entry_t entries     [Depth];
    entry_t entries_nxt [Depth];

    logic [Depth-1:0]      free_vec;
    logic [Depth-1:0]      match_0;
    logic [Depth-1:0]      match_1;
    logic [Depth-1:0]      rd_match;
    logic [Depth-1:0]      wr_match;
    logic [Depth-1:0]      valid_nxt;
    logic [SLOT_W-1:0]     free_idx;
    logic                  any_free;
    logic                  elig_0;
    logic                  elig_1;
    logic                  prio_1;
    logic [ENT_TAG_W-1:0]  wr_tag;
    logic [ENT_DATA_W-1:0] wr_payload;
    logic [ENT_DATA_W-1:0] rd_data_nxt;
    logic                  rd_hit_nxt;
    logic [CNT_W-1:0]      cnt_nxt;

    function automatic logic [CNT_W-1:0] popcount(input logic [Depth-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < Depth; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    lowest_free_enc #(
        .N     (Depth),
        .IDX_W (SLOT_W)
    ) u_free_enc (
        .free_vec (free_vec),
        .idx      (free_idx),
        .any_free (any_free)
    );

    // Tag comparison against pre-edge contents
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            free_vec[i] = ~entries[i].valid;
            match_0[i]  = entries[i].valid && (entries[i].tag == ENT_TAG_W'(wr_index_0));
            match_1[i]  = entries[i].valid && (entries[i].tag == ENT_TAG_W'(wr_index_1));
            rd_match[i] = rd_req && entries[i].valid && (entries[i].tag == ENT_TAG_W'(rd_index));
        end
    end

`ifdef TAG_CACHE_RR_EN
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (wr_gnt_0) begin
            rr_ptr <= 1'b1;
        end else if (wr_gnt_1) begin
            rr_ptr <= 1'b0;
        end
    end

    assign prio_1 = rr_ptr;
`else
    assign prio_1 = 1'b0;
`endif

    // A requester is only eligible if its write can land: existing tag or a free slot
    always_comb begin
        elig_0   = wr_req_0 && !rst && ((|match_0) || any_free);
        elig_1   = wr_req_1 && !rst && ((|match_1) || any_free);
        wr_gnt_1 = elig_1 && (!elig_0 || prio_1);
        wr_gnt_0 = elig_0 && !wr_gnt_1;
    end

    always_comb begin
        entries_nxt = entries;
        wr_match    = wr_gnt_1 ? match_1 : match_0;
        wr_tag      = wr_gnt_1 ? ENT_TAG_W'(wr_index_1) : ENT_TAG_W'(wr_index_0);
        wr_payload  = wr_gnt_1 ? ENT_DATA_W'(wr_data_1) : ENT_DATA_W'(wr_data_0);
        rd_hit_nxt  = |rd_match;
        rd_data_nxt = '0;
        for (int i = 0; i < Depth; i++) begin
            if (rd_match[i]) begin
                rd_data_nxt          = rd_data_nxt | entries[i].data;
                entries_nxt[i].valid = 1'b0;
            end
        end
        // The write is applied after the release so a same-tag write keeps the entry alive
        if (wr_gnt_0 || wr_gnt_1) begin
            if (|wr_match) begin
                for (int i = 0; i < Depth; i++) begin
                    if (wr_match[i]) begin
                        entries_nxt[i].valid = 1'b1;
                        entries_nxt[i].data  = wr_payload;
                    end
                end
            end else begin
                entries_nxt[free_idx].valid = 1'b1;
                entries_nxt[free_idx].tag   = wr_tag;
                entries_nxt[free_idx].data  = wr_payload;
            end
        end
        for (int i = 0; i < Depth; i++) begin
            valid_nxt[i] = entries_nxt[i].valid;
        end
        cnt_nxt = popcount(valid_nxt);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < Depth; i++) begin
            entries[i] <= entries_nxt[i];
            if (rst) begin
                entries[i].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
            rd_data  <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            rd_valid <= rd_req;
            rd_hit   <= rd_hit_nxt;
            rd_data  <= Data_Width'(rd_data_nxt);
            count    <= cnt_nxt;
            full     <= (cnt_nxt == CNT_W'(Depth));
            empty    <= (cnt_nxt == '0);
        end
    end

endmodule
